id_exe_ctrl: RTL and testbench
==============================

# id_exe_ctrl

ID→EX control stage of the 5-stage ARM core. It decodes the ID-stage instruction fields (mode, opcode, S, cond) into the 4-bit ALU command and memory/writeback/branch controls, and registers them into the EX stage. It owns the architectural NZCV status register that feeds the ALU `SR` input and captures the ALU `status` output. It evaluates the ARM condition field, forwarding in-flight flags from EX, and squashes failed, flushed or illegal instructions into bubbles.

## Interface
Parameters: none.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_mode` in 2: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `id_opcode` in 4: ARM data-processing opcode.
- `id_s` in 1: S bit; for memory mode, 1 = LDR and 0 = STR.
- `id_cond` in 4: ARM condition field.
- `stall` in 1: hold the EX register and SR.
- `flush` in 1: load a bubble into EX; has priority over `stall`.
- `alu_status` in 4: ALU NZCV result for the instruction currently in EX (combinational, same cycle).
- `ex_valid` out 1: EX holds a real instruction.
- `ex_cmd` out 4: ALU command.
- `ex_mem_read`, `ex_mem_write`, `ex_wb_en`, `ex_branch`, `ex_s` out 1 each: registered EX controls.
- `sr` out 4: architectural {N,Z,C,V}; drives the ALU SR input.

## Operation
- Decode map, mode 00, opcode→cmd:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011.
  - SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111.
  - EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
- Mode 00 controls:
  - `wb_en` = 1 except CMP and TST.
  - `ex_s` = `id_s`, forced to 1 for CMP and TST.
  - Any other opcode: cmd 0000, `wb_en` 0, `ex_s` 0; still valid.
- Mode 01: cmd 0010, `ex_s` 0. LDR: `mem_read` 1, `wb_en` 1. STR: `mem_write` 1.
- Mode 10: cmd 0000, `branch` 1, `ex_s` 0, `wb_en` 0.
- Mode 11: treated as a bubble.
- Effective flags F = (`ex_valid` & `ex_s`) ? `alu_status` : `sr`. This is the forward from an instruction still in EX.
- Condition pass uses standard ARM codes on F:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 never passes.
- EX advance condition: `flush` | !`stall`. On advance:
  - If `flush`, or !`id_valid`, or mode 11, or cond fails: bubble. All outputs 0, including `ex_cmd` 0000.
  - Otherwise: load the decoded controls with `ex_valid` 1.
- Without advance: all EX outputs hold.
- SR update: on an advance edge where the outgoing EX has `ex_valid` & `ex_s`, `sr` ← `alu_status`. Otherwise `sr` holds.
- A stalled S instruction updates `sr` exactly once, when it finally leaves EX.
- A flushed EX instruction that set S still commits its flags. Only the ID instruction is squashed.

## Timing
- Reset (edge with `rst_n`=0): all EX outputs 0, `ex_cmd` 0000, `sr` 0000. Reset overrides `flush` and `stall`.
- Latency: ID fields to EX outputs in 1 cycle. SR commit occurs 1 cycle after the S instruction enters EX.
- Back-to-back: an S instruction in EX followed by a conditional instruction in ID evaluates against `alu_status` with zero bubbles.
- `stall` & `flush` together: flush wins, the bubble loads, and the outgoing EX flags commit.
- Condition evaluation and decode are combinational on ID inputs; no combinational path from ID to outputs.

## Structure
- Shared package `arm_pkg` holds:
  - ALU cmd constants, e.g. `CMD_MOV`=0001.
  - ARM opcode constants.
  - Mode encodings.
  - Condition code constants (EQ..AL).
- Sub-module `cond_check`: combinational, inputs cond[3:0] and flags[3:0], output pass. It is reusable by the WB and branch logic.
- The top level contains the decode logic, the EX pipeline register and the SR register.

## Test plan
- Reset with `id_valid`=1 ADD AL: all outputs 0 and `sr`=0000 while `rst_n`=0. The first edge after release gives `ex_cmd`=0010, `wb_en`=1.
- CMP S (EX, `alu_status`=0100) followed by MOVEQ in ID: MOVEQ enters EX with `ex_cmd`=0001, `ex_valid`=1. `sr`=0100 on the same edge.
- `sr`=0000, ID ADDNE then SUBEQ, each with no flag-setting instruction ahead: ADDNE valid with cmd 0010; SUBEQ becomes a bubble with cmd 0000.
- ADDS in EX held by 3 cycles of `stall` with `alu_status`=0011: EX outputs hold, `sr` stays unchanged. `sr` becomes 0011 only on the edge `stall` drops.
- `flush`=1 with `stall`=1, ID LDR AL: EX becomes a bubble with all controls 0.
- Decode sweep: LDR gives cmd 0010, `mem_read` 1, `wb_en` 1, `ex_s` 0. STR gives `mem_write` 1. Branch gives `ex_branch` 1. TST gives cmd 0110, `ex_s` 1, `wb_en` 0. Mode 11 gives a bubble. Cond 1111 gives a bubble.

Source files
------------

// File: rtl/id_exe_ctrl_pkg.sv
// Shared ARM encodings for the ID->EX control stage: ALU commands, opcodes,
// instruction modes, condition codes and the EX control bundle.
package arm_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       s;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_exe_ctrl_if.sv
// ID/EX control bundle: ID instruction fields and pipeline controls in, EX controls and SR out.
interface id_exe_ctrl_if;
    logic       id_valid;
    logic [1:0] id_mode;
    logic [3:0] id_opcode;
    logic       id_s;
    logic [3:0] id_cond;
    logic       stall;
    logic       flush;
    logic [3:0] alu_status;

    logic       ex_valid;
    logic [3:0] ex_cmd;
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       ex_wb_en;
    logic       ex_branch;
    logic       ex_s;
    logic [3:0] sr;

    modport master (
        output id_valid, id_mode, id_opcode, id_s, id_cond, stall, flush, alu_status,
        input  ex_valid, ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, sr
    );

    modport slave (
        input  id_valid, id_mode, id_opcode, id_s, id_cond, stall, flush, alu_status,
        output ex_valid, ex_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, sr
    );
endinterface

// File: rtl/id_exe_ctrl_cond_check.sv
// ARM condition-field evaluator against NZCV flags; purely combinational.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = flags;
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/id_exe_ctrl.sv
// ID->EX control stage: decodes ID fields into EX controls, owns the NZCV
// status register and squashes failed, flushed or illegal instructions.
module id_exe_ctrl
    import arm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_exe_ctrl_if.slave bus
);
    ex_ctrl_t   ex_q, ex_d;
    ex_ctrl_t   dec;
    logic [3:0] sr_q, sr_d;
    logic [3:0] flags_eff;
    logic       cond_pass;
    logic       advance;

    // Forward flags from an S instruction still in EX so a dependent
    // conditional in ID needs no bubble.
    assign flags_eff = (ex_q.valid && ex_q.s) ? bus.alu_status : sr_q;
    assign advance   = bus.flush || !bus.stall;

    cond_check u_cond_check (
        .cond  (bus.id_cond),
        .flags (flags_eff),
        .pass  (cond_pass)
    );

    always_comb begin
        dec       = EX_BUBBLE;
        dec.valid = 1'b1;
        case (bus.id_mode)
            MODE_DP: begin
                dec.wb_en = 1'b1;
                dec.s     = bus.id_s;
                case (bus.id_opcode)
                    OP_MOV:  dec.cmd = CMD_MOV;
                    OP_MVN:  dec.cmd = CMD_MVN;
                    OP_ADD:  dec.cmd = CMD_ADD;
                    OP_ADC:  dec.cmd = CMD_ADC;
                    OP_SUB:  dec.cmd = CMD_SUB;
                    OP_SBC:  dec.cmd = CMD_SBC;
                    OP_AND:  dec.cmd = CMD_AND;
                    OP_ORR:  dec.cmd = CMD_ORR;
                    OP_EOR:  dec.cmd = CMD_EOR;
                    OP_CMP: begin
                        dec.cmd   = CMD_SUB;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    OP_TST: begin
                        dec.cmd   = CMD_AND;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b1;
                    end
                    default: begin
                        dec.cmd   = CMD_NOP;
                        dec.wb_en = 1'b0;
                        dec.s     = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                dec.cmd       = CMD_ADD;
                dec.mem_read  = bus.id_s;
                dec.wb_en     = bus.id_s;
                dec.mem_write = !bus.id_s;
            end
            MODE_BR: begin
                dec.branch = 1'b1;
            end
            default: dec = EX_BUBBLE;
        endcase
    end

    // SR commits from the outgoing EX instruction, even when ID is flushed.
    always_comb begin
        ex_d = ex_q;
        sr_d = sr_q;
        if (advance) begin
            if (ex_q.valid && ex_q.s) begin
                sr_d = bus.alu_status;
            end
            if (bus.flush || !bus.id_valid || bus.id_mode == MODE_ILL || !cond_pass) begin
                ex_d = EX_BUBBLE;
            end else begin
                ex_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= EX_BUBBLE;
            sr_q <= '0;
        end else begin
            ex_q <= ex_d;
            sr_q <= sr_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_cmd       = ex_q.cmd;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_wb_en     = ex_q.wb_en;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_s         = ex_q.s;
    assign bus.sr           = sr_q;
endmodule

// File: tb/tb_id_exe_ctrl.sv
// Scoreboard bench for id_exe_ctrl: directed ID vectors with hand-computed EX/SR results.
module tb_id_exe_ctrl;

    typedef struct packed {
        logic       v;
        logic [3:0] cmd;
        logic       mr;
        logic       mw;
        logic       wb;
        logic       br;
        logic       s;
        logic [3:0] sr;
    } exp_t;

    logic clk;
    logic rst_n;
    id_exe_ctrl_if bus ();

    id_exe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   step_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    function automatic exp_t mk(input logic v, input logic [3:0] cmd, input logic mr,
                                input logic mw, input logic wb, input logic br,
                                input logic s, input logic [3:0] sr);
        exp_t e;
        e = {v, cmd, mr, mw, wb, br, s, sr};
        return e;
    endfunction

    function automatic exp_t bub(input logic [3:0] sr);
        return mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sr);
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [1:0] md,
                       input logic [3:0] op, input logic s, input logic [3:0] cd,
                       input logic st, input logic fl, input logic [3:0] alu,
                       input exp_t e);
        @(negedge clk);
        rst_n          = r;
        bus.id_valid   = v;
        bus.id_mode    = md;
        bus.id_opcode  = op;
        bus.id_s       = s;
        bus.id_cond    = cd;
        bus.stall      = st;
        bus.flush      = fl;
        bus.alu_status = alu;
        step++;
        sb_q.push_back(e);
        step_q.push_back(step);
    endtask

    // Monitor: every sampled cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        exp_t act;
        int   id;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                id  = step_q.pop_front();
                act = {bus.ex_valid, bus.ex_cmd, bus.ex_mem_read, bus.ex_mem_write,
                       bus.ex_wb_en, bus.ex_branch, bus.ex_s, bus.sr};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL step%0d got v=%b cmd=%b mr=%b mw=%b wb=%b br=%b s=%b sr=%b want v=%b cmd=%b mr=%b mw=%b wb=%b br=%b s=%b sr=%b",
                             id, act.v, act.cmd, act.mr, act.mw, act.wb, act.br, act.s, act.sr,
                             e.v, e.cmd, e.mr, e.mw, e.wb, e.br, e.s, e.sr);
                end
            end
        end
    end

    localparam logic [1:0] DP = 2'b00, MEM = 2'b01, BR = 2'b10, ILL = 2'b11;
    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, CC = 4'b0011, MI = 4'b0100;
    localparam logic [3:0] VS = 4'b0110, HI = 4'b1000, LS = 4'b1001, GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011, GT = 4'b1100, AL = 4'b1110, NV = 4'b1111;

    initial begin
        rst_n          = 1'b0;
        bus.id_valid   = 1'b0;
        bus.id_mode    = '0;
        bus.id_opcode  = '0;
        bus.id_s       = 1'b0;
        bus.id_cond    = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.alu_status = '0;

        //   rst  v   mode op       s     cond st    fl    alu      expected after edge
        // Reset with ADD AL present, then reset overriding stall/flush
        cyc(1'b0, 1, DP,  4'b0100, 1'b0, AL, 1'b0, 1'b0, 4'b0000, bub(4'b0000));
        cyc(1'b0, 1, DP,  4'b0100, 1'b0, AL, 1'b1, 1'b1, 4'b0000, bub(4'b0000));
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 0, 0, 1, 0, 0, 4'b0000));
        // CMP; outgoing ADD has no S so alu must not commit
        cyc(1'b1, 1, DP,  4'b1010, 1'b0, AL, 1'b0, 1'b0, 4'b1111, mk(1, 4'b0100, 0, 0, 0, 0, 1, 4'b0000));
        // MOVEQ forwarded from CMP's alu_status=0100, SR commits same edge
        cyc(1'b1, 1, DP,  4'b1101, 1'b0, EQ, 1'b0, 1'b0, 4'b0100, mk(1, 4'b0001, 0, 0, 1, 0, 0, 4'b0100));
        // ADDNE against SR Z=1 fails
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, NE, 1'b0, 1'b0, 4'b0000, bub(4'b0100));
        // Re-reset, then ADDNE passes and SUBEQ fails with SR=0000
        cyc(1'b0, 0, DP,  4'b0000, 1'b0, AL, 1'b0, 1'b0, 4'b0000, bub(4'b0000));
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, NE, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 0, 0, 1, 0, 0, 4'b0000));
        cyc(1'b1, 1, DP,  4'b0010, 1'b0, EQ, 1'b0, 1'b0, 4'b0000, bub(4'b0000));
        // ADDS held by 3 stall cycles; SR commits only when stall drops
        cyc(1'b1, 1, DP,  4'b0100, 1'b1, AL, 1'b0, 1'b0, 4'b0011, mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b0000));
        cyc(1'b1, 1, DP,  4'b1101, 1'b0, AL, 1'b1, 1'b0, 4'b0011, mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b0000));
        cyc(1'b1, 1, DP,  4'b1101, 1'b0, AL, 1'b1, 1'b0, 4'b0011, mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b0000));
        cyc(1'b1, 1, DP,  4'b1101, 1'b0, AL, 1'b1, 1'b0, 4'b0011, mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b0000));
        cyc(1'b1, 1, DP,  4'b1101, 1'b0, AL, 1'b0, 1'b0, 4'b0011, mk(1, 4'b0001, 0, 0, 1, 0, 0, 4'b0011));
        // flush+stall with LDR in ID gives a bubble
        cyc(1'b1, 1, MEM, 4'b0000, 1'b1, AL, 1'b1, 1'b1, 4'b0000, bub(4'b0011));
        // Flushed S instruction in EX still commits its flags
        cyc(1'b1, 1, DP,  4'b0100, 1'b1, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 0, 0, 1, 0, 1, 4'b0011));
        cyc(1'b1, 1, MEM, 4'b0000, 1'b1, AL, 1'b1, 1'b1, 4'b1000, bub(4'b1000));
        // Decode sweep: LDR, STR, B, TST, illegal mode, cond NV
        cyc(1'b1, 1, MEM, 4'b0000, 1'b1, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 1, 0, 1, 0, 0, 4'b1000));
        cyc(1'b1, 1, MEM, 4'b0000, 1'b0, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 0, 1, 0, 0, 0, 4'b1000));
        cyc(1'b1, 1, BR,  4'b0000, 1'b0, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0000, 0, 0, 0, 1, 0, 4'b1000));
        cyc(1'b1, 1, DP,  4'b1000, 1'b0, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0110, 0, 0, 0, 0, 1, 4'b1000));
        cyc(1'b1, 1, ILL, 4'b0100, 1'b0, AL, 1'b0, 1'b0, 4'b0110, bub(4'b0110));
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, NV, 1'b0, 1'b0, 4'b0000, bub(4'b0110));
        // SR=0110 (Z,C): GE passes, LT fails, invalid ID bubbles, unknown opcode is a valid NOP
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, GE, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0010, 0, 0, 1, 0, 0, 4'b0110));
        cyc(1'b1, 1, DP,  4'b0001, 1'b0, LT, 1'b0, 1'b0, 4'b0000, bub(4'b0110));
        cyc(1'b1, 0, DP,  4'b0100, 1'b0, AL, 1'b0, 1'b0, 4'b0000, bub(4'b0110));
        cyc(1'b1, 1, DP,  4'b0011, 1'b1, AL, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0110));
        cyc(1'b1, 1, DP,  4'b1100, 1'b1, HI, 1'b0, 1'b0, 4'b0000, bub(4'b0110));
        cyc(1'b1, 1, DP,  4'b1100, 1'b1, LS, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0111, 0, 0, 1, 0, 1, 4'b0110));
        // ORRS in EX with alu=1001 forwarded: SBCGT passes
        cyc(1'b1, 1, DP,  4'b0110, 1'b0, GT, 1'b0, 1'b0, 4'b1001, mk(1, 4'b0101, 0, 0, 1, 0, 0, 4'b1001));
        cyc(1'b1, 1, DP,  4'b1111, 1'b0, MI, 1'b0, 1'b0, 4'b0000, mk(1, 4'b1001, 0, 0, 1, 0, 0, 4'b1001));
        cyc(1'b1, 1, DP,  4'b0101, 1'b0, CC, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0011, 0, 0, 1, 0, 0, 4'b1001));
        cyc(1'b1, 1, DP,  4'b0000, 1'b0, VS, 1'b0, 1'b0, 4'b0000, mk(1, 4'b0110, 0, 0, 1, 0, 0, 4'b1001));
        cyc(1'b1, 1, DP,  4'b0100, 1'b0, EQ, 1'b0, 1'b0, 4'b0000, bub(4'b1001));

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
